// File: rtl/piso_ctrl_pkg.sv
// Shared types and defaults for the round-robin serial transmit controller.
package piso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_N    = 8;
  localparam int DEF_NREQ = 4;

  // Grant index width; kept at least 1 so a degenerate requester count still yields a legal vector.
  function automatic int calc_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr, wrapping.
module rr_arbiter
  import piso_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int             idx;
  logic           found;
  logic [IDW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDW'(idx);
      if (!found && req[sel]) begin
        found   = 1'b1;
        gnt_idx = sel;
      end
    end
    gnt[gnt_idx] = en & found;
  end

endmodule

// File: rtl/piso_rr_tx_ctrl.sv
// Shares one MSB-first shift path among NREQ word requesters with round-robin
// arbitration and a valid/ready serial handshake.
module piso_rr_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] p_data,
  output logic [NREQ-1:0]   ack,
  output logic              s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id
);

  localparam int CW = $clog2(N);

  state_t         state_reg;
  logic [N-1:0]   shreg_reg;
  logic [CW-1:0]  cnt_reg;
  logic           last_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] gnt_id_reg;

  logic [N-1:0]    words [NREQ];
  logic            cap;
  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
      assign words[gi] = p_data[gi*N +: N];
    end
  endgenerate

  // A new word may be taken when idle, or on the final accepted beat for a gapless reload.
  assign cap    = (|req) && ((state_reg == IDLE) ||
                  ((state_reg == SHIFT) && s_ready && last_reg));
  assign arb_en = cap && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ack      = gnt;
  assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      last_reg   <= 1'b0;
      ptr_reg    <= '0;
      gnt_id_reg <= '0;
    end else if (cap) begin
      state_reg  <= SHIFT;
      shreg_reg  <= words[gnt_idx];
      cnt_reg    <= '0;
      last_reg   <= 1'b0;
      ptr_reg    <= ptr_next;
      gnt_id_reg <= gnt_idx;
    end else if ((state_reg == SHIFT) && s_ready) begin
      if (last_reg) begin
        state_reg <= IDLE;
        last_reg  <= 1'b0;
      end else begin
        shreg_reg <= {shreg_reg[N-2:0], 1'b0};
        cnt_reg   <= cnt_reg + 1'b1;
        last_reg  <= (cnt_reg == CW'(N - 2));
      end
    end
  end

  assign s_data  = shreg_reg[N-1];
  assign s_valid = (state_reg == SHIFT);
  assign busy    = (state_reg == SHIFT);
  assign s_last  = last_reg;
  assign gnt_id  = gnt_id_reg;

endmodule

// File: tb/tb_piso_rr_tx_ctrl.sv
// Scoreboard bench: a round-robin reference model predicts grants and pushes expected
// serial beats; a monitor pops and compares them on every accepted beat.
module tb_piso_rr_tx_ctrl;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] p_data;
  logic [NREQ-1:0]   ack;
  logic              s_data, s_valid, s_ready, s_last, busy;
  logic [IDW-1:0]    gnt_id;

  piso_rr_tx_ctrl #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .p_data  (p_data),
    .ack     (ack),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .busy    (busy),
    .gnt_id  (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    int   gid;
  } beat_t;

  beat_t          expq[$];
  int             gnt_log[$];
  int             mptr = 0;
  logic [NREQ-1:0] served = '0;
  int             errors = 0;
  int             checks = 0;
  logic           chk_rst = 1'b0;

  // Requester-side stimulus state
  logic [NREQ-1:0] pend = '0;
  logic [N-1:0]    word [NREQ];
  bit              refill = 0;
  bit              rand_mode = 0;
  int              rdy_mode = 0;
  int              bp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model: samples mid-low-phase when inputs and ack are settled.
  initial begin
    forever begin
      bit   idle, cap_e;
      int   w;
      logic [N-1:0] wd;
      @(negedge clk);
      #2;
      if (rst) begin
        chk("ack_in_reset", 32'(ack), 32'd0);
        expq.delete();
        mptr    = 0;
        chk_rst = 1'b1;
      end else begin
        if (chk_rst) begin
          chk("rst_s_valid", 32'(s_valid), 32'd0);
          chk("rst_s_data", 32'(s_data), 32'd0);
          chk("rst_s_last", 32'(s_last), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_gnt_id", 32'(gnt_id), 32'd0);
          chk_rst = 1'b0;
        end
        idle  = (expq.size() == 0);
        cap_e = (req != 0) && (idle || (s_ready && expq.size() == 1));
        w = 0;
        if (cap_e) begin
          for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
          end
        end
        chk("ack", 32'(ack), cap_e ? (32'd1 << w) : 32'd0);
        if (!idle) begin
          chk("s_valid", 32'(s_valid), 32'd1);
          chk("busy", 32'(busy), 32'd1);
          chk("s_data", 32'(s_data), 32'(expq[0].b));
          chk("s_last", 32'(s_last), (expq.size() == 1) ? 32'd1 : 32'd0);
          chk("gnt_id", 32'(gnt_id), 32'(expq[0].gid));
          if (s_ready) void'(expq.pop_front());
        end else begin
          chk("idle_s_valid", 32'(s_valid), 32'd0);
          chk("idle_busy", 32'(busy), 32'd0);
        end
        if (cap_e) begin
          wd = p_data[w*N +: N];
          for (int b = N - 1; b >= 0; b--) expq.push_back('{b: wd[b], gid: w});
          mptr      = (w + 1) % NREQ;
          served[w] = 1'b1;
          gnt_log.push_back(w);
          $display("grant id=%0d word=%02h t=%0t", w, wd, $time);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (served[i]) begin
        served[i] = 1'b0;
        pend[i]   = 1'b0;
        if (refill) begin
          pend[i] = 1'b1;
          word[i] = N'($urandom);
        end
      end
      if (rand_mode) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          word[i] = N'($urandom);
        end else if (pend[i] && $urandom_range(0, 30) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    if (rand_mode) rst = ($urandom_range(0, 199) == 0);
    case (rdy_mode)
      0: s_ready = 1'b1;
      1: begin
        s_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end
      default: s_ready = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req[i]          = pend[i];
      p_data[i*N +: N] = word[i];
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((pend != 0 || expq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", bound);
    end
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    p_data  = '0;
    s_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) word[i] = '0;
    do_reset();
    step();

    // Single word 8'hD6 from requester 0
    pend[0] = 1'b1; word[0] = 8'hD6;
    wait_idle(40);

    // Contention: requesters 0 and 2 back-to-back
    pend[0] = 1'b1; word[0] = 8'hA5;
    pend[2] = 1'b1; word[2] = 8'h3C;
    wait_idle(60);

    // Fairness: all requesters continuously pending, starting from ptr=0
    do_reset();
    gnt_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1;
      word[i] = N'($urandom);
    end
    refill = 1;
    for (int n = 0; n < 200 && gnt_log.size() < 8; n++) step();
    refill = 0;
    wait_idle(100);
    chk("fair_count", 32'(gnt_log.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("fair_order", 32'(gnt_log[k]), 32'(k % 4));

    // Backpressure on word 8'h81
    rdy_mode = 1; bp_cnt = 0;
    pend[0] = 1'b1; word[0] = 8'h81;
    wait_idle(80);
    rdy_mode = 0;

    // Reset after three accepted bits of 8'hFF, then ptr must restart at 0
    pend[1] = 1'b1; word[1] = 8'hFF;
    step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pend[3] = 1'b1; word[3] = 8'h0F;
    pend[0] = 1'b1; word[0] = 8'h5A;
    gnt_log.delete();
    wait_idle(60);
    chk("post_rst_first", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'd0);

    // Random traffic with random backpressure, drops and resets
    rand_mode = 1; rdy_mode = 2;
    repeat (3000) step();
    rand_mode = 0; rdy_mode = 0; rst = 1'b0;
    wait_idle(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_rr_tx_ctrl.md
# piso_rr_tx_ctrl

Round-robin transmit controller that shares one parallel-in/serial-out shift path between several parallel-word requesters. It arbitrates among pending requests, captures the winning word, and shifts it out MSB-first under a valid/ready serial handshake. It frames each word with a last-bit marker. It sits between word-level producers and a single-bit serial sink.

## Interface
- N, 8, word width in bits (≥2)
- NREQ, 4, number of requesters (≥2)
- IDW, $clog2(NREQ), width of grant index
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester word valid; held with stable data until acked
- p_data  in  NREQ*N  requester words; requester i at bits [i*N +: N]
- ack  out  NREQ  one-hot capture strobe; requester i's word is taken on the edge ending the cycle ack[i]=1
- s_data  out  1  serial bit, MSB of current word first
- s_valid  out  1  s_data is valid
- s_ready  in  1  sink accepts s_data on this edge when s_valid=1
- s_last  out  1  current bit is bit 0 (final bit) of the word
- busy  out  1  a word is in flight (state SHIFT)
- gnt_id  out  IDW  index of requester whose word is shifting; holds last value in IDLE

## Operation
- States: IDLE, SHIFT.
- Capture condition: `cap = |req & (state==IDLE | (s_valid & s_ready & s_last))`.
- On cap:
  - Round-robin winner w is chosen. Search starts at ptr and wraps modulo NREQ.
  - ack[w]=1, combinational in that cycle.
  - At the edge: shreg←p_data[w], cnt←0, gnt_id←w, ptr←(w+1) mod NREQ, state→SHIFT.
- SHIFT:
  - s_valid=1, s_data=shreg[N-1], s_last=(cnt==N-1).
  - On s_ready & !s_last: shreg←shreg<<1 (LSB filled with 0), cnt←cnt+1.
  - On s_ready & s_last: if cap, reload back-to-back with no idle cycle; otherwise state→IDLE.
- Stall: while s_valid & !s_ready, s_data, s_last, cnt, shreg and gnt_id hold. No ack is issued.
- ack is 0 whenever cap=0. At most one ack bit is set per cycle.
- Requests arriving mid-word wait; arbitration samples req only at a cap cycle.
- Dropping req before ack is legal; the requester is not served.
- Reset (any cycle, including mid-word):
  - state←IDLE, ptr←0, cnt←0, shreg←0, gnt_id←0.
  - The partial word is discarded.
  - ack is forced 0 during reset.
- Reset values: s_data=0, s_valid=0, s_last=0, busy=0, ack=0, gnt_id=0.

## Timing
- Latency: req asserted in IDLE at cycle k gives ack in cycle k. The first bit (MSB) appears at s_valid in cycle k+1.
- One word occupies exactly N accepted s_ready beats. With s_ready held 1, the word spans cycles k+1..k+N and s_last=1 at k+N.
- Back-to-back: the next word's ack coincides with the previous word's last accepted bit. s_valid stays 1 continuously.
- Throughput: 1 bit/cycle; N cycles per word with no gap under continuous requests.
- All outputs except ack are registered. ack is combinational from state, req, ptr, s_ready and s_last.
- s_data and s_valid never change while s_valid & !s_ready.

## Structure
- Package piso_ctrl_pkg holds:
  - state typedef enum {IDLE, SHIFT}
  - default N/NREQ localparams
  - a function computing IDW
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req, ptr, en
  - outputs: one-hot gnt, index gnt_idx
  - purely combinational
  - the top keeps ptr, FSM, counter and shift register.
- Counter width is $clog2(N); compare against N-1 exactly. No wrap beyond N-1 is reachable.

## Test plan
- Single word: req[0]=1, p_data[0]=8'hD6, s_ready=1.
  - ack[0] is 1 for one cycle.
  - s_data sequence is 1,1,0,1,0,1,1,0.
  - s_last=1 only on the 8th bit.
  - busy drops the cycle after the 8th bit.
- Contention: req=4'b0101 held, words 8'hA5 (req 0) and 8'h3C (req 2).
  - Output is 8'hA5 then 8'h3C back-to-back, 16 contiguous valid cycles.
  - gnt_id goes 0→2; ack[2] coincides with the s_last of the first word.
- Fairness: req=4'hF held for 8 words.
  - Grant order is 0,1,2,3,0,1,2,3.
  - ack is one-hot every time.
- Backpressure: s_ready toggles 1,0,0,1,... during word 8'h81.
  - s_data holds through each stall.
  - Exactly 8 accepted beats produce 1,0,0,0,0,0,0,1.
  - s_last holds across a stall on bit 0.
- Reset mid-word: assert rst after 3 bits of 8'hFF.
  - The next cycle has all outputs at reset values and ptr=0.
  - A new req[3] with 8'h0F then serializes fully from its MSB.
